openhw_cvtint_sched: RTL and testbench



---
 rtl/openhw_cvtint_sched_if.sv | 32 +++
 rtl/openhw_cvtint_sched.sv | 127 ++++++++++++
 tb/tb_openhw_cvtint_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/openhw_cvtint_sched_if.sv
// Request/result bundle for the shared float-to-integer post-processing datapath.
// Requesters and the result consumer sit on the master side; the scheduler uses the slave side.
interface openhw_cvtint_sched_if #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
);
  logic [1:0]      ReqValid;
  logic [1:0]      ReqReady;
  logic [XLEN-1:0] ReqMag0;
  logic [XLEN-1:0] ReqMag1;
  logic [6:0]      ReqCtl0;
  logic [6:0]      ReqCtl1;
  logic [TAGW-1:0] ReqTag0;
  logic [TAGW-1:0] ReqTag1;
  logic            ResValid;
  logic            ResReady;
  logic [XLEN-1:0] ResData;
  logic            ResNV;
  logic            ResNX;
  logic [TAGW-1:0] ResTag;
  logic            ResSrc;

  modport master (
    output ReqValid, ReqMag0, ReqMag1, ReqCtl0, ReqCtl1, ReqTag0, ReqTag1, ResReady,
    input  ReqReady, ResValid, ResData, ResNV, ResNX, ResTag, ResSrc
  );

  modport slave (
    input  ReqValid, ReqMag0, ReqMag1, ReqCtl0, ReqCtl1, ReqTag0, ReqTag1, ResReady,
    output ReqReady, ResValid, ResData, ResNV, ResNX, ResTag, ResSrc
  );
endinterface

// File: rtl/openhw_cvtint_sched.sv
// Two-requester round-robin scheduler in front of a 2-stage round / negate / saturate
// pipeline producing the final FCVT.W/WU/L/LU integer plus NV/NX flags.
module openhw_cvtint_sched #(
  parameter int XLEN = 64,
  parameter int TAGW = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  openhw_cvtint_sched_if.slave bus
);

  logic            ptr;
  logic [1:0]      grant;
  logic            adv1;
  logic            adv2;
  logic            take;
  logic [XLEN-1:0] sel_mag;
  logic [6:0]      sel_ctl;
  logic [TAGW-1:0] sel_tag;

  // S1 keeps the Mag+Plus1 carry; flags are {Signed, Int64, Xs, NaN, Ovf, Inexact}
  logic            s1_valid;
  logic [XLEN:0]   s1_m;
  logic [5:0]      s1_flg;
  logic [TAGW-1:0] s1_tag;
  logic            s1_src;

  logic [64:0] m;
  logic [64:0] max_s;
  logic [64:0] min_mag_s;
  logic [64:0] max_u;
  logic        sg;
  logic        i64;
  logic        xs;
  logic        nan;
  logic        inv;
  logic [63:0] r;

  always_comb begin
    grant[0] = bus.ReqValid[0] & (~bus.ReqValid[1] | ~ptr);
    grant[1] = bus.ReqValid[1] & (~bus.ReqValid[0] | ptr);
  end

  assign adv2         = bus.ResReady | ~bus.ResValid;
  assign adv1         = adv2 | ~s1_valid;
  assign bus.ReqReady = grant & {2{adv1}};
  assign take         = adv1 & (|grant);

  always_comb begin
    sel_mag = grant[1] ? bus.ReqMag1 : bus.ReqMag0;
    sel_ctl = grant[1] ? bus.ReqCtl1 : bus.ReqCtl0;
    sel_tag = grant[1] ? bus.ReqTag1 : bus.ReqTag0;
  end

  // Pointer only moves past the requester it names once that requester transfers
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (adv1 && grant[ptr]) begin
      ptr <= ~ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_flg   <= '0;
      s1_tag   <= '0;
      s1_src   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= take;
      if (take) begin
        s1_m   <= {1'b0, sel_mag} + {{XLEN{1'b0}}, sel_ctl[4]};
        s1_flg <= {sel_ctl[6:5], sel_ctl[3:0]};
        s1_tag <= sel_tag;
        s1_src <= grant[1];
      end
    end
  end

  always_comb begin
    m         = 65'(s1_m);
    sg        = s1_flg[5];
    i64       = s1_flg[4] && (XLEN == 64);
    xs        = s1_flg[3];
    nan       = s1_flg[2];
    max_s     = i64 ? 65'h0_7FFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_7FFF_FFFF;
    min_mag_s = i64 ? 65'h0_8000_0000_0000_0000 : 65'h0_0000_0000_8000_0000;
    max_u     = i64 ? 65'h0_FFFF_FFFF_FFFF_FFFF : 65'h0_0000_0000_FFFF_FFFF;
    inv = nan | s1_flg[1]
        | (sg & ~xs & (m > max_s))
        | (sg & xs & (m > min_mag_s))
        | (~sg & ~xs & (m > max_u))
        | (~sg & xs & (m != '0));
    if (inv) begin
      if (nan || !xs) r = sg ? max_s[63:0] : max_u[63:0];
      else            r = sg ? ~max_s[63:0] : '0;
    end else begin
      r = m[63:0];
      if (xs) r = -r;
    end
    // 32-bit results always sign-replicate bit 31, unsigned W conversions included
    if (!i64) r[63:32] = {32{r[31]}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.ResValid <= 1'b0;
      bus.ResData  <= '0;
      bus.ResNV    <= 1'b0;
      bus.ResNX    <= 1'b0;
      bus.ResTag   <= '0;
      bus.ResSrc   <= 1'b0;
    end else if (adv2) begin
      bus.ResValid <= s1_valid;
      if (s1_valid) begin
        bus.ResData <= r[XLEN-1:0];
        bus.ResNV   <= inv;
        bus.ResNX   <= s1_flg[0] & ~inv;
        bus.ResTag  <= s1_tag;
        bus.ResSrc  <= s1_src;
      end
    end
  end

endmodule

// File: tb/tb_openhw_cvtint_sched.sv
// Bench for openhw_cvtint_sched: directed conversion vectors, arbitration, stalls, reset,
// and randomized traffic scored against a value-range reference model.
module tb_openhw_cvtint_sched;
  localparam int XLEN = 64;
  localparam int TAGW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  openhw_cvtint_sched_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();
  openhw_cvtint_sched #(.XLEN(XLEN), .TAGW(TAGW)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [63:0] data;
    logic        nv;
    logic        nx;
    logic [4:0]  tag;
    logic        src;
  } res_t;

  res_t exp_q[$];
  res_t got_q[$];
  int checks = 0;
  int errors = 0;

  // Conversion reference: signed value range test against [lo, hi] of the target type
  function automatic res_t model(input logic [63:0] mag, input logic [6:0] ctl,
                                 input logic [4:0] tag, input logic src);
    res_t o;
    int unsigned n;
    logic signed [67:0] v, lo, hi, rr;
    logic inv;
    n = ctl[5] ? 64 : 32;
    v = $signed({4'b0, mag}) + $signed({67'b0, ctl[4]});
    if (ctl[3]) v = -v;
    if (ctl[6]) begin
      lo = -(68'sd1 <<< (n - 1));
      hi = (68'sd1 <<< (n - 1)) - 68'sd1;
    end else begin
      lo = 68'sd0;
      hi = (68'sd1 <<< n) - 68'sd1;
    end
    inv = ctl[2] | ctl[1] | (v < lo) | (v > hi);
    rr = !inv ? v : ((ctl[2] | !ctl[3]) ? hi : lo);
    o.data = (n == 32) ? {{32{rr[31]}}, rr[31:0]} : rr[63:0];
    o.nv = inv;
    o.nx = ctl[0] & !inv;
    o.tag = tag;
    o.src = src;
    return o;
  endfunction

  function automatic logic [63:0] rnd_mag();
    case ($urandom % 8)
      0: return 64'h0;
      1: return 64'h0000_0000_7FFF_FFFF;
      2: return 64'h0000_0000_8000_0000;
      3: return 64'h0000_0000_FFFF_FFFF;
      4: return 64'h7FFF_FFFF_FFFF_FFFF;
      5: return 64'hFFFF_FFFF_FFFF_FFFF;
      6: return {$urandom, $urandom};
      default: return 64'($urandom % 8);
    endcase
  endfunction

  function automatic logic [6:0] rnd_ctl();
    logic [6:0] c;
    c = 7'($urandom);
    c[2] = ($urandom % 8) == 0;
    c[1] = ($urandom % 8) == 0;
    return c;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.ReqValid[0] && bus.ReqReady[0])
        exp_q.push_back(model(bus.ReqMag0, bus.ReqCtl0, bus.ReqTag0, 1'b0));
      if (bus.ReqValid[1] && bus.ReqReady[1])
        exp_q.push_back(model(bus.ReqMag1, bus.ReqCtl1, bus.ReqTag1, 1'b1));
      if (bus.ResValid && bus.ResReady)
        got_q.push_back({bus.ResData, bus.ResNV, bus.ResNX, bus.ResTag, bus.ResSrc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [4:0] t0, input logic [4:0] t1);
    bus.ReqValid = v;
    bus.ReqMag0 = rnd_mag();
    bus.ReqMag1 = rnd_mag();
    bus.ReqCtl0 = rnd_ctl();
    bus.ReqCtl1 = rnd_ctl();
    bus.ReqTag0 = t0;
    bus.ReqTag1 = t1;
  endtask

  task automatic do_reset();
    bus.ReqValid = 2'b00;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic drain();
    bus.ReqValid = 2'b00;
    bus.ResReady = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    drive(2'b11, 5'd1, 5'd2);
    bus.ResReady = 1'b1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.ResValid, bus.ResData, bus.ResNV, bus.ResNX, bus.ResTag, bus.ResSrc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h nv=%b nx=%b tag=%h src=%b, want all 0",
               bus.ResValid, bus.ResData, bus.ResNV, bus.ResNX, bus.ResTag, bus.ResSrc);
    end
    checks++;
    if (bus.ReqReady !== 2'b01) begin
      errors++;
      $display("FAIL reset_grant: ReqReady=%b want 01", bus.ReqReady);
    end
    bus.ReqValid = 2'b00;
  endtask

  localparam int ND = 11;
  localparam logic [63:0] D_MAG [ND] = '{
    64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'h5, 64'h0, 64'h0, 64'hFFFF_FFFF,
    64'h8000_0000, 64'h8000_0000, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
  localparam logic [6:0] D_CTL [ND] = '{
    7'b1010000, 7'b1011000, 7'b0001000, 7'b0001001, 7'b1100101, 7'b0010000,
    7'b1011000, 7'b0000001, 7'b1101000, 7'b0110000, 7'b1000010};
  localparam logic [63:0] D_RES [ND] = '{
    64'h0000_0000_7FFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'h0, 64'h0,
    64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000,
    64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
    64'h0000_0000_7FFF_FFFF};
  localparam logic [1:0] D_FLG [ND] = '{
    2'b10, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b10, 2'b10};

  task automatic test_conversions();
    do_reset();
    bus.ResReady = 1'b1;
    for (int k = 0; k < ND; k++) begin
      bus.ReqValid = 2'b01;
      bus.ReqMag0 = D_MAG[k];
      bus.ReqCtl0 = D_CTL[k];
      bus.ReqTag0 = 5'(k);
      tick();
      bus.ReqValid = 2'b00;
      checks++;
      if (bus.ResValid !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d]: ResValid=%b want 0", k, bus.ResValid);
      end
      tick();
      checks++;
      if ({bus.ResValid, bus.ResData, bus.ResNV, bus.ResNX, bus.ResTag, bus.ResSrc} !==
          {1'b1, D_RES[k], D_FLG[k], 5'(k), 1'b0}) begin
        errors++;
        $display("FAIL conv[%0d]: valid=%b data=%h nv=%b nx=%b tag=%0d src=%b, want 1 %h %b tag %0d src 0",
                 k, bus.ResValid, bus.ResData, bus.ResNV, bus.ResNX, bus.ResTag, bus.ResSrc,
                 D_RES[k], D_FLG[k], k);
      end
    end
    drain();
  endtask

  task automatic test_arbitration();
    logic [4:0] et;
    do_reset();
    bus.ResReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) drive(2'b11, 5'(k), 5'(k + 16));
      else bus.ReqValid = 2'b00;
      #1;
      if (k < 6) begin
        checks++;
        if (bus.ReqReady !== ((k % 2) ? 2'b10 : 2'b01)) begin
          errors++;
          $display("FAIL arb_grant[%0d]: ReqReady=%b want %b", k, bus.ReqReady,
                   (k % 2) ? 2'b10 : 2'b01);
        end
      end
      if (k >= 2) begin
        et = ((k - 2) % 2) ? 5'(k - 2 + 16) : 5'(k - 2);
        checks++;
        if ({bus.ResValid, bus.ResSrc, bus.ResTag} !== {1'b1, 1'(k % 2), et}) begin
          errors++;
          $display("FAIL arb_result[%0d]: valid=%b src=%b tag=%0d want 1 %0d %0d",
                   k, bus.ResValid, bus.ResSrc, bus.ResTag, k % 2, et);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    do_reset();
    bus.ResReady = 1'b0;
    drive(2'b11, 5'd3, 5'd19);
    #1;
    checks++;
    if (bus.ReqReady !== 2'b01) begin
      errors++;
      $display("FAIL bp_first: ReqReady=%b want 01", bus.ReqReady);
    end
    tick();
    drive(2'b11, 5'd4, 5'd20);
    #1;
    checks++;
    if (bus.ReqReady !== 2'b10) begin
      errors++;
      $display("FAIL bp_second: ReqReady=%b want 10", bus.ReqReady);
    end
    tick();
    drive(2'b11, 5'd5, 5'd21);
    #1;
    held = bus.ResData;
    checks++;
    if ({bus.ReqReady, bus.ResValid} !== 3'b001) begin
      errors++;
      $display("FAIL bp_stall: ReqReady=%b ResValid=%b want 00 1", bus.ReqReady, bus.ResValid);
    end
    tick();
    checks++;
    if ({bus.ReqReady, bus.ResValid, bus.ResData} !== {3'b001, held}) begin
      errors++;
      $display("FAIL bp_hold: ReqReady=%b ResValid=%b data=%h want 00 1 %h",
               bus.ReqReady, bus.ResValid, bus.ResData, held);
    end
    bus.ResReady = 1'b1;
    #1;
    checks++;
    if (bus.ReqReady !== 2'b01) begin
      errors++;
      $display("FAIL bp_release_ptr: ReqReady=%b want 01", bus.ReqReady);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      drive(2'(($urandom % 3) + 1), 5'($urandom), 5'($urandom));
      bus.ResReady = ($urandom % 2) == 0;
    end
    tick();
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results want %0d (at least 4)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_item[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    bus.ResReady = 1'b0;
    drive(2'b01, 5'd7, 5'd8);
    tick();
    bus.ReqValid = 2'b00;
    tick();
    drive(2'b10, 5'd9, 5'd10);
    #1;
    checks++;
    if (bus.ReqReady !== 2'b10) begin
      errors++;
      $display("FAIL bubble_accept: ReqReady=%b want 10", bus.ReqReady);
    end
    tick();
    checks++;
    if ({bus.ReqReady, bus.ResValid, bus.ResTag} !== {2'b00, 1'b1, 5'd7}) begin
      errors++;
      $display("FAIL bubble_full: ReqReady=%b valid=%b tag=%0d want 00 1 7",
               bus.ReqReady, bus.ResValid, bus.ResTag);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    bus.ResReady = 1'b0;
    drive(2'b11, 5'd1, 5'd2);
    tick();
    tick();
    checks++;
    if ({bus.ReqReady, bus.ResValid} !== 3'b001) begin
      errors++;
      $display("FAIL mid_full: ReqReady=%b ResValid=%b want 00 1", bus.ReqReady, bus.ResValid);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.ResValid, bus.ReqReady} !== 3'b001) begin
      errors++;
      $display("FAIL mid_reset: ResValid=%b ReqReady=%b want 0 01", bus.ResValid, bus.ReqReady);
    end
    bus.ReqValid = 2'b00;
    bus.ResReady = 1'b1;
    tick();
    checks++;
    if (bus.ResValid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: ResValid=%b want 0", bus.ResValid);
    end
    drain();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      drive(2'($urandom), 5'($urandom), 5'($urandom));
      bus.ResReady = ($urandom % 4) != 0;
      #1;
      checks++;
      if ($countones(bus.ReqReady) > 1 || (bus.ReqReady & ~bus.ReqValid) != 2'b00) begin
        errors++;
        $display("FAIL rnd_grant[%0d]: ReqReady=%b ReqValid=%b", k, bus.ReqReady, bus.ReqValid);
      end
      tick();
    end
    drain();
    checks++;
    if (got_q.size() != exp_q.size() || got_q.size() < 100) begin
      errors++;
      $display("FAIL rnd_count: got %0d results want %0d (at least 100)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rnd_item[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.ReqValid = 2'b00;
    bus.ResReady = 1'b1;
    bus.ReqMag0 = '0;
    bus.ReqMag1 = '0;
    bus.ReqCtl0 = '0;
    bus.ReqCtl1 = '0;
    bus.ReqTag0 = '0;
    bus.ReqTag1 = '0;
    test_reset();
    test_conversions();
    test_arbitration();
    test_backpressure();
    test_bubble();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
